// File: rtl/sync_fifo_x8.sv
// Single-clock byte FIFO with standard (registered, non-fall-through) read data
// and an occupancy counter; full/empty are registered from the next count.
module sync_fifo_x8 #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   data_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;
  logic [CW-1:0]    count_nxt;

  // Accept decisions use the registered flags, so a full FIFO never takes a write
  // even when a read frees a slot in the same cycle.
  always_comb begin
    wr_acc    = wr_en && !full;
    rd_acc    = rd_en && !empty;
    count_nxt = data_count;
    if (wr_acc && !rd_acc) begin
      count_nxt = data_count + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_nxt = data_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout       <= '0;
      data_count <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      data_count <= count_nxt;
      full       <= (count_nxt == CW'(DEPTH));
      empty      <= (count_nxt == '0);
    end
  end

  // Storage is not cleared on reset; stale entries are unreachable once empty.
  always_ff @(posedge clk) begin
    if (!srst && wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: tb/tb_sync_fifo_x8.sv
// Self-checking bench: 256- and 1024-deep FIFOs driven with identical stimulus,
// each compared against a queue-based reference model.
module tb_sync_fifo_x8;

  logic       clk;
  logic       srst;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] din;

  logic [7:0]  dout_a;
  logic        full_a;
  logic        empty_a;
  logic [8:0]  count_a;
  logic [7:0]  dout_b;
  logic        full_b;
  logic        empty_b;
  logic [10:0] count_b;

  int checks;
  int failures;

  byte unsigned q_a[$];
  byte unsigned q_b[$];
  logic [7:0]   exp_a;
  logic [7:0]   exp_b;

  sync_fifo_x8 #(.DEPTH(256), .WIDTH(8)) dut_a (
    .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout_a), .full(full_a), .empty(empty_a), .data_count(count_a)
  );

  sync_fifo_x8 #(.DEPTH(1024), .WIDTH(8)) dut_b (
    .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout_b), .full(full_b), .empty(empty_b), .data_count(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive inputs, advance both models at the edge, settle 1 time unit past it.
  task automatic cyc(input logic w, input logic r, input logic s, input logic [7:0] d);
    wr_en = w;
    rd_en = r;
    srst  = s;
    din   = d;
    @(posedge clk);
    if (s) begin
      q_a.delete();
      q_b.delete();
      exp_a = 8'h00;
      exp_b = 8'h00;
    end else begin
      automatic bit wa = w && (q_a.size() < 256);
      automatic bit ra = r && (q_a.size() > 0);
      automatic bit wb = w && (q_b.size() < 1024);
      automatic bit rb = r && (q_b.size() > 0);
      if (ra) exp_a = q_a.pop_front();
      if (wa) q_a.push_back(d);
      if (rb) exp_b = q_b.pop_front();
      if (wb) q_b.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b1, 8'hEE);
    checks++;
    if (empty_a !== 1'b1 || full_a !== 1'b0 || count_a !== 9'd0 || dout_a !== 8'h00) begin
      failures++;
      $display("FAIL reset_a got e=%b f=%b c=%0d d=%h exp e=1 f=0 c=0 d=00",
               empty_a, full_a, count_a, dout_a);
    end
    checks++;
    if (empty_b !== 1'b1 || full_b !== 1'b0 || count_b !== 11'd0 || dout_b !== 8'h00) begin
      failures++;
      $display("FAIL reset_b got e=%b f=%b c=%0d d=%h exp e=1 f=0 c=0 d=00",
               empty_b, full_b, count_b, dout_b);
    end
  endtask

  task automatic test_single();
    cyc(1'b1, 1'b0, 1'b0, 8'hA5);
    checks++;
    if (empty_a !== 1'b0 || count_a !== 9'd1) begin
      failures++;
      $display("FAIL single_write got e=%b c=%0d exp e=0 c=1", empty_a, count_a);
    end
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (dout_a !== 8'hA5 || empty_a !== 1'b1 || dout_b !== 8'hA5) begin
      failures++;
      $display("FAIL single_read got da=%h db=%h e=%b exp A5 A5 e=1", dout_a, dout_b, empty_a);
    end
  endtask

  task automatic test_fill_overflow();
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 256; i++) cyc(1'b1, 1'b0, 1'b0, 8'(i));
    checks++;
    if (full_a !== 1'b1 || count_a !== 9'd256) begin
      failures++;
      $display("FAIL fill got f=%b c=%0d exp f=1 c=256", full_a, count_a);
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h55);
    checks++;
    if (full_a !== 1'b1 || count_a !== 9'd256 || count_b !== 11'd257) begin
      failures++;
      $display("FAIL overflow got fa=%b ca=%0d cb=%0d exp 1 256 257", full_a, count_a, count_b);
    end
    for (int i = 0; i < 256; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      checks++;
      if (dout_a !== 8'(i) || dout_b !== 8'(i)) begin
        failures++;
        $display("FAIL drain[%0d] got a=%h b=%h exp %h", i, dout_a, dout_b, 8'(i));
      end
    end
    checks++;
    if (empty_a !== 1'b1 || count_a !== 9'd0 || full_a !== 1'b0) begin
      failures++;
      $display("FAIL drain_end got e=%b c=%0d f=%b exp e=1 c=0 f=0", empty_a, count_a, full_a);
    end
  endtask

  task automatic test_underflow();
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h3C);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'hFF);
      checks++;
      if (dout_a !== 8'h3C || count_a !== 9'd0 || empty_a !== 1'b1 || dout_b !== 8'h3C) begin
        failures++;
        $display("FAIL underflow got da=%h db=%h c=%0d e=%b exp 3C 3C 0 1",
                 dout_a, dout_b, count_a, empty_a);
      end
    end
  endtask

  task automatic test_simultaneous();
    int bad;
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'h77);
    checks++;
    if (count_a !== 9'd1 || dout_a !== 8'h00 || empty_a !== 1'b0) begin
      failures++;
      $display("FAIL both_on_empty got c=%0d d=%h e=%b exp 1 00 0", count_a, dout_a, empty_a);
    end
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'(i));
      checks++;
      if (count_a !== 9'd10 || dout_a !== exp_a || dout_b !== exp_b) begin
        failures++;
        if (bad < 5) $display("FAIL stream[%0d] got c=%0d d=%h exp c=10 d=%h", i, count_a, dout_a, exp_a);
        bad++;
      end
    end
    for (int i = 0; i < 246; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
    cyc(1'b1, 1'b1, 1'b0, 8'h12);
    checks++;
    if (count_a !== 9'd255 || full_a !== 1'b0 || dout_a !== exp_a) begin
      failures++;
      $display("FAIL both_on_full got c=%0d f=%b d=%h exp 255 0 %h", count_a, full_a, dout_a, exp_a);
    end
  endtask

  task automatic test_wrap_and_reset();
    int total;
    int n;
    int bad;
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    total = 0;
    bad = 0;
    while (total < 3000) begin
      n = $urandom_range(1, 900);
      if (n > 3000 - total) n = 3000 - total;
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
      for (int i = 0; i < n; i++) begin
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        checks++;
        if (dout_b !== exp_b || count_b !== 11'(q_b.size())) begin
          failures++;
          if (bad < 5) $display("FAIL wrap[%0d] got d=%h c=%0d exp d=%h c=%0d",
                                total + i, dout_b, count_b, exp_b, q_b.size());
          bad++;
        end
      end
      total += n;
    end
    for (int i = 0; i < 700; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
    checks++;
    if (count_b !== 11'd700) begin
      failures++;
      $display("FAIL pre_reset_count got %0d exp 700", count_b);
    end
    cyc(1'b1, 1'b1, 1'b1, 8'hAB);
    checks++;
    if (count_b !== 11'd0 || empty_b !== 1'b1 || dout_b !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset got c=%0d e=%b d=%h exp 0 1 00", count_b, empty_b, dout_b);
    end
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (dout_b !== 8'h00 || empty_b !== 1'b1) begin
      failures++;
      $display("FAIL stale_read got d=%h e=%b exp 00 1", dout_b, empty_b);
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h9E);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (dout_b !== 8'h9E || empty_b !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_data got d=%h e=%b exp 9E 1", dout_b, empty_b);
    end
  endtask

  task automatic test_random();
    int bad;
    int wp;
    bad = 0;
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      wp = (i / 500) % 2 == 0 ? 70 : 30;
      cyc(($urandom % 100) < wp, ($urandom % 100) < (100 - wp), ($urandom % 400) == 0, 8'($urandom));
      checks++;
      if (dout_a !== exp_a || count_a !== 9'(q_a.size()) ||
          full_a !== (q_a.size() == 256) || empty_a !== (q_a.size() == 0)) begin
        failures++;
        if (bad < 5) $display("FAIL rand_a[%0d] got d=%h c=%0d f=%b e=%b exp d=%h c=%0d",
                              i, dout_a, count_a, full_a, empty_a, exp_a, q_a.size());
        bad++;
      end
      checks++;
      if (dout_b !== exp_b || count_b !== 11'(q_b.size()) ||
          full_b !== (q_b.size() == 1024) || empty_b !== (q_b.size() == 0)) begin
        failures++;
        if (bad < 5) $display("FAIL rand_b[%0d] got d=%h c=%0d f=%b e=%b exp d=%h c=%0d",
                              i, dout_b, count_b, full_b, empty_b, exp_b, q_b.size());
        bad++;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_a    = 8'h00;
    exp_b    = 8'h00;
    srst     = 1'b1;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    din      = 8'h00;
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    test_reset();
    test_single();
    test_fill_overflow();
    test_underflow();
    test_simultaneous();
    test_wrap_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_x8.md
# sync_fifo_x8

Single-clock, synchronous-reset first-in/first-out buffer with standard (non-first-word-fall-through) read timing and an occupancy counter. It serves as the byte-wide elastic buffer between a data source and downstream consumers. The design chains three depth variants of this block: 512, 256 and 1024 entries. Each variant is this block with a different `DEPTH`.

## Interface
- `DEPTH`, default 512: number of storage entries; power of two, ≥ 4. The design instantiates 256, 512 and 1024.
- `WIDTH`, default 8: data width in bits.
- `clk`, input, 1: sole clock; all logic on the rising edge.
- `srst`, input, 1: reset, synchronous and active-high.
- `din`, input, `WIDTH`: write data.
- `wr_en`, input, 1: write request.
- `rd_en`, input, 1: read request.
- `dout`, output, `WIDTH`: read data, registered.
- `full`, output, 1: FIFO holds `DEPTH` entries.
- `empty`, output, 1: FIFO holds 0 entries.
- `data_count`, output, log2(`DEPTH`)+1: current occupancy, 0..`DEPTH`.

## Operation
- Storage: a `DEPTH` × `WIDTH` array.
  - Write pointer and read pointer are log2(`DEPTH`) bits wide and wrap naturally modulo `DEPTH`.
  - Occupancy is a counter with log2(`DEPTH`)+1 bits.
- Accepted write: `wr_en` = 1 and `full` = 0.
  - `din` is stored at the write pointer.
  - The write pointer increments.
- Accepted read: `rd_en` = 1 and `empty` = 0.
  - The entry at the read pointer is loaded into `dout`.
  - The read pointer increments.
- Rejected requests:
  - A write while `full` = 1 is ignored. Memory, pointers and count are unchanged; this holds even if a read is accepted in the same cycle.
  - A read while `empty` = 1 is ignored. `dout` holds its previous value.
- Count update per edge: +1 for a write-only accept, −1 for a read-only accept, unchanged when both are accepted or neither is.
- Flags are derived from the next count and registered:
  - `full` = (count == `DEPTH`).
  - `empty` = (count == 0).
- Simultaneous events:
  - When empty with `wr_en` and `rd_en` both high, only the write is accepted. The count goes to 1 and `dout` is unchanged.
  - When full with both high, only the read is accepted. The count goes to `DEPTH`−1.
  - When partially filled with both high, both are accepted. The count is unchanged and ordering is preserved.
- `dout` holds its last read value indefinitely until the next accepted read.
- Reset (`srst` = 1 at a rising edge), regardless of any in-flight operation:
  - Pointers go to 0, `data_count` to 0, `empty` to 1, `full` to 0, `dout` to 0.
  - `wr_en` and `rd_en` are ignored in reset cycles.
  - Memory contents need not be cleared; stale data is never readable because the FIFO is empty.
- Ordering: data emerges in write order with no loss or duplication while no write-on-full or read-on-empty occurs.

## Timing
- All outputs are registered and change only on a rising edge of `clk`.
- Read latency: `rd_en` sampled high at edge N (with `empty` = 0) makes the data valid on `dout` after edge N, i.e. during cycle N+1.
- Flag and count latency: after an accepted access at edge N, the new `empty`, `full` and `data_count` are valid after edge N.
- Write-to-read latency:
  - A write at edge N deasserts `empty` after edge N.
  - The earliest read is at edge N+1, and that data appears on `dout` after edge N+1.
- Sustained rate: one write and one read per cycle, indefinitely, when partially filled.
- Reset: outputs take their reset values after the first edge with `srst` = 1. The first accepted write is at the first edge with `srst` = 0.

## Test plan
- **Reset values:** drive data, then pulse `srst` for one cycle. Required: `empty` = 1, `full` = 0, `data_count` = 0, `dout` = 0 on the next cycle.
- **Single-entry latency:** write 0xA5 at edge N.
  - `empty` = 0 and `data_count` = 1 after N.
  - Read at N+1; `dout` = 0xA5 and `empty` = 1 after N+1.
- **Fill and overflow (`DEPTH` = 256):**
  - Write 0x00..0xFF. Required: `full` = 1 and `data_count` = 256.
  - Further write 0x55. Required: ignored, count stays 256.
  - Drain all 256. Required: `dout` sequence 0x00..0xFF, then `empty` = 1.
- **Underflow:** read while empty with `dout` last = 0x3C. Required: `dout` stays 0x3C, count stays 0, `empty` stays 1.
- **Simultaneous read/write:**
  - At count 10, hold both high for 1000 cycles with an incrementing `din`. Required: count stays 10 and output is in order.
  - When empty with both high: count becomes 1.
  - When full with both high: count becomes `DEPTH`−1.
- **Reset mid-operation and wrap:**
  - With `DEPTH` = 1024, pass 3000 bytes in bursts, so pointers wrap. Required: the data is intact.
  - Assert `srst` at count 700. Required: count 0 and `empty` = 1 next cycle, with no old data returned afterward.
